register: RTL and testbench
===========================

REGISTER -- requirements
Module: register

Interface
REQ-001 Parameter n, default 8, data width in bits; legal range 1..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 read  input  1  read enable; when high, the stored value is transferred to out at the clock edge.
REQ-005 write  input  1  write enable; when high, in is captured into storage at the clock edge.
REQ-006 in  input  n  write data.
REQ-007 out  output  n  read data; registered, driven only from flops.
REQ-008 Port order SHALL be clk, rst, read, write, in, out.

Function
REQ-009 The module SHALL hold one internal n-bit storage word (stored) and one n-bit output register (out).
REQ-010 Rising edge, write=1, read=0: stored <= in; out unchanged.
REQ-011 Rising edge, read=1, write=0: out <= stored; stored unchanged.
REQ-012 Rising edge, read=1, write=1: stored <= in and out <= in (write-first bypass); the same-edge write is visible on out immediately.
REQ-013 Rising edge, read=0, write=0: stored and out both hold.
REQ-014 Read latency SHALL be one clock: out reflects the value captured at the edge where read=1 and is stable until the next read edge.
REQ-015 Write latency SHALL be one clock: a read at the edge following a write returns the written data.
REQ-016 out SHALL never change on an edge where read=0, regardless of write or in activity.
REQ-017 No handshake or back-pressure; every enable is honoured on every edge.
REQ-018 Data SHALL be stored bit-exact, without truncation, extension or arithmetic.
REQ-019 X or Z on read or write SHALL never be treated as asserted by the verification environment (simulation assertion), and the design SHALL hold state in that case.

Reset
REQ-020 rst=1 SHALL clear stored and out to 0 immediately, without waiting for a clock edge.
REQ-021 While rst=1, read and write SHALL be ignored and both registers SHALL stay 0.
REQ-022 After rst deasserts, the first rising edge SHALL operate normally, per REQ-010..013.
REQ-023 Reset asserted mid-operation, including on an edge with read=1 and write=1, SHALL win over any capture.

Structure
REQ-024 A shared package SHALL provide the default width constant (8) and the reset value constant (0); the module SHALL take its parameter default from it.
REQ-025 A single flat module is sufficient; no sub-module is required.
REQ-026 Storage and output flops SHALL sit in a single sequential process with an asynchronous reset branch; the module SHALL contain no latches and no combinational path from in to out.

Verification
REQ-027 Reset: rst=1 with in=8'hFF, write=1, read=1 for 2 edges -> out=0 throughout; rst low, read=1 -> out=0.
REQ-028 Write then read: write=1, read=0, in=8'h24 -> out holds 0; next edge read=1, write=0, in=8'h81 -> out=8'h24; stored still 8'h24.
REQ-029 Simultaneous: read=1, write=1, in=8'h09 -> out=8'h09 at that edge; next edge read=1, write=0, in=8'h63 -> out stays 8'h09.
REQ-030 Write without read: write=1, read=0, in=8'h0D -> out keeps 8'h09; next edge read=1, write=0, in=8'h8D -> out=8'h0D.
REQ-031 Idle hold: after out=8'h0D, 5 edges with read=0, write=0 and random in -> out and stored stay 8'h0D.
REQ-032 Async reset mid-cycle: assert rst between edges while out=8'h0D -> out=0 before next edge; width sweep n=1 and n=32 repeats REQ-028 with all-ones data.

Source files
------------

// File: rtl/register_pkg.sv
// Shared constants for the register block: default data width and reset value.
package register_pkg;

  // Data width used when the instantiating code does not override it.
  localparam int DEFAULT_WIDTH = 8;

  // Widest data word the register supports.
  localparam int MAX_WIDTH = 64;

  // Value both storage and output take while reset is held.
  localparam logic [MAX_WIDTH-1:0] RESET_VALUE = '0;

endpackage

// File: rtl/register.sv
// Single-word storage register with a registered read port.
// A write captures data into the storage word.
// A read copies the storage word into the output register.
// When read and write happen on the same edge, the new write data goes
// straight to the output.
module register
  import register_pkg::*;
#(
  parameter int n = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         read,
  input  logic         write,
  input  logic [n-1:0] in,
  output logic [n-1:0] out
);

  logic [n-1:0] stored;

  // Storage and output flops share one process. Reset clears both at once
  // and wins over any capture. An unknown enable falls through to the hold
  // branch, so X on read or write never changes state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stored <= RESET_VALUE[n-1:0];
      out    <= RESET_VALUE[n-1:0];
    end else if (read && write) begin
      stored <= in;
      out    <= in;
    end else if (write) begin
      stored <= in;
    end else if (read) begin
      out <= stored;
    end
  end

endmodule

// File: tb/tb_register.sv
// Directed testbench for the register block at widths 8, 1 and 32.
module tb_register;

  logic        clk;
  logic        rst;
  logic        read;
  logic        write;
  logic [7:0]  in8;
  logic [0:0]  in1;
  logic [31:0] in32;
  logic [7:0]  out8;
  logic [0:0]  out1;
  logic [31:0] out32;

  int vectorCount;
  int missCount;

  register #(.n(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .read  (read),
    .write (write),
    .in    (in8),
    .out   (out8)
  );

  register #(.n(1)) dutNarrow (
    .clk   (clk),
    .rst   (rst),
    .read  (read),
    .write (write),
    .in    (in1),
    .out   (out1)
  );

  register #(.n(32)) dutWide (
    .clk   (clk),
    .rst   (rst),
    .read  (read),
    .write (write),
    .in    (in32),
    .out   (out32)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Enables driven into the design must always be known at a clock edge.
  always @(posedge clk) begin
    if (rst === 1'b0) begin
      assert (!$isunknown(read) && !$isunknown(write))
        else $error("[TB] unknown enable at clock edge");
    end
  end

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drives one set of inputs at the falling edge, then waits until just
  // after the next rising edge so outputs can be sampled.
  task automatic applyStimulus(input logic rstVal, input logic rd,
                               input logic wr, input logic [7:0] data);
    @(negedge clk);
    rst   = rstVal;
    read  = rd;
    write = wr;
    in8   = data;
    in1   = data[0];
    in32  = {4{data}};
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectorCount = 0;
    missCount   = 0;

    // Reset held with every enable active and all-ones data.
    rst   = 1'b1;
    read  = 1'b1;
    write = 1'b1;
    in8   = 8'hFF;
    in1   = 1'b1;
    in32  = 32'hFFFF_FFFF;
    #1;
    checkOutput("reset_immediate", {56'd0, out8}, 64'h0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF);
      checkOutput("reset_hold_out", {56'd0, out8}, 64'h0);
      checkOutput("reset_hold_stored", {56'd0, dut.stored}, 64'h0);
    end

    // The first edge after reset operates normally and reads zero.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hFF);
    checkOutput("post_reset_read", {56'd0, out8}, 64'h0);

    // Write then read.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h24);
    checkOutput("write_out_holds", {56'd0, out8}, 64'h0);
    checkOutput("write_stored", {56'd0, dut.stored}, 64'h24);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h81);
    checkOutput("read_after_write", {56'd0, out8}, 64'h24);
    checkOutput("read_stored_kept", {56'd0, dut.stored}, 64'h24);

    // Simultaneous read and write bypasses the new data to the output.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h09);
    checkOutput("bypass_out", {56'd0, out8}, 64'h09);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h63);
    checkOutput("bypass_reread", {56'd0, out8}, 64'h09);

    // Write without read leaves the output untouched.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h0D);
    checkOutput("write_only_out", {56'd0, out8}, 64'h09);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h8D);
    checkOutput("write_only_read", {56'd0, out8}, 64'h0D);

    // Idle edges with changing data hold everything.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'($urandom));
      checkOutput("idle_out", {56'd0, out8}, 64'h0D);
      checkOutput("idle_stored", {56'd0, dut.stored}, 64'h0D);
    end

    // Reset asserted between edges clears the output before the next edge.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_out", {56'd0, out8}, 64'h0);
    checkOutput("async_reset_stored", {56'd0, dut.stored}, 64'h0);

    // Reset wins over a read-and-write edge.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hAA);
    checkOutput("reset_beats_capture", {56'd0, out8}, 64'h0);

    // First edge after release bypasses normally.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h5A);
    checkOutput("release_bypass", {56'd0, out8}, 64'h5A);

    // Width sweep with all-ones data on the 1-bit and 32-bit instances.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
    checkOutput("narrow_write_out", {63'd0, out1}, 64'h0);
    checkOutput("wide_write_out", {32'd0, out32}, 64'h0);
    checkOutput("wide_write_stored", {32'd0, dutWide.stored}, 64'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("narrow_read", {63'd0, out1}, 64'h1);
    checkOutput("wide_read", {32'd0, out32}, 64'hFFFF_FFFF);
    checkOutput("narrow_stored_kept", {63'd0, dutNarrow.stored}, 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
